// File: rtl/keccak_arbiter_pkg.sv
// Shared types and defaults for the two-requester keccak arbiter.
package pkg_keccak;

  localparam int IN_BUF_SIZE     = 64;
  localparam int DIGEST_W        = 256;
  localparam int KA_FLUSH_CYCLES = 2;
  localparam int KA_TIMEOUT      = 4096;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    WAIT_DIGEST,
    FLUSH
  } arb_state_t;

endpackage

// File: rtl/keccak_arbiter_slot.sv
// One-entry result register: digest, owner id and abort flag, popped with valid/ready.
module keccak_result_slot
  import pkg_keccak::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cap_valid,
  input  logic                cap_id,
  input  logic [DIGEST_W-1:0] cap_digest,
  input  logic                cap_error,
  input  logic                res_ready,
  output logic                res_valid,
  output logic                res_id,
  output logic [DIGEST_W-1:0] res_digest,
  output logic                res_error
);

  logic                valid_q, valid_d;
  logic                id_q, id_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                error_q, error_d;

  // Payload is kept after a pop; only a new capture replaces it.
  always_comb begin
    valid_d  = valid_q;
    id_d     = id_q;
    digest_d = digest_q;
    error_d  = error_q;
    if (cap_valid) begin
      valid_d  = 1'b1;
      id_d     = cap_id;
      digest_d = cap_digest;
      error_d  = cap_error;
    end else if (valid_q && res_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      id_q     <= 1'b0;
      digest_q <= '0;
      error_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      id_q     <= id_d;
      digest_q <= digest_d;
      error_q  <= error_d;
    end
  end

  assign res_valid  = valid_q;
  assign res_id     = id_q;
  assign res_digest = digest_q;
  assign res_error  = error_q;

endmodule

// File: rtl/keccak_arbiter.sv
// Round-robin sharing of one keccak core between two message requesters,
// one whole message per grant, with a core reset between messages.
//
// state       | meaning
// IDLE        | core clean; arbitrate when the result slot is free or popping
// FEED        | forward granted requester's words until its eom word
// WAIT_DIGEST | wait for core digest, watchdog running
// FLUSH       | hold core reset for FLUSH_CYCLES cycles
module keccak_arbiter
  import pkg_keccak::*;
#(
  parameter int FLUSH_CYCLES = KA_FLUSH_CYCLES,
  parameter int TIMEOUT      = KA_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [IN_BUF_SIZE-1:0] req0_data,
  input  logic                   req0_last,
  input  logic                   req0_eom,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [IN_BUF_SIZE-1:0] req1_data,
  input  logic                   req1_last,
  input  logic                   req1_eom,
  output logic                   req1_ready,
  output logic [IN_BUF_SIZE-1:0] k_din,
  output logic                   k_din_valid,
  output logic                   k_last_block,
  output logic                   k_reset,
  input  logic                   k_buffer_full,
  input  logic                   k_ready,
  input  logic [DIGEST_W-1:0]    k_dout,
  input  logic                   k_dout_valid,
  output logic                   res_valid,
  output logic                   res_id,
  output logic [DIGEST_W-1:0]    res_digest,
  output logic                   res_error,
  input  logic                   res_ready,
  output logic                   busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  arb_state_t          state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [TW-1:0]       wd_q, wd_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                cap_valid;
  logic                cap_error;
  logic [DIGEST_W-1:0] cap_digest;
  logic                slot_free;
  logic                g_valid, g_last, g_eom;

  assign g_valid   = grant_q ? req1_valid : req0_valid;
  assign g_last    = grant_q ? req1_last  : req0_last;
  assign g_eom     = grant_q ? req1_eom   : req0_eom;
  assign slot_free = !res_valid || res_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    fcnt_d       = fcnt_q;
    cap_valid    = 1'b0;
    cap_error    = 1'b0;
    cap_digest   = '0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) grant_d = !last_grant_q;
          else                          grant_d = req1_valid;
          last_grant_d = grant_d;
          state_d      = FEED;
        end
      end
      FEED: begin
        req0_ready = !grant_q && !k_buffer_full;
        req1_ready = grant_q && !k_buffer_full;
        if (g_valid && !k_buffer_full && g_eom) begin
          state_d = WAIT_DIGEST;
          wd_d    = '0;
        end
      end
      WAIT_DIGEST: begin
        // A digest arriving on the timeout cycle still counts as success.
        if (k_dout_valid) begin
          cap_valid  = 1'b1;
          cap_digest = k_dout;
          state_d    = FLUSH;
          fcnt_d     = FW'(FLUSH_CYCLES - 1);
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          cap_valid = 1'b1;
          cap_error = 1'b1;
          state_d   = FLUSH;
          fcnt_d    = FW'(FLUSH_CYCLES - 1);
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = IDLE;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wd_q         <= '0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign k_din        = grant_q ? req1_data : req0_data;
  assign k_din_valid  = (state_q == FEED) && g_valid && !k_buffer_full;
  assign k_last_block = (state_q == FEED) && g_last;
  assign k_reset      = reset || (state_q == FLUSH);
  assign busy         = (state_q != IDLE);

  keccak_result_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .cap_valid  (cap_valid),
    .cap_id     (grant_q),
    .cap_digest (cap_digest),
    .cap_error  (cap_error),
    .res_ready  (res_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_digest (res_digest),
    .res_error  (res_error)
  );

  // Requester contract: the message-ending word must sit in the final block.
  a_eom_has_last: assert property (@(posedge clk) disable iff (reset)
    (k_din_valid && g_eom) |-> g_last);

  a_core_ready_after_flush: assert property (@(posedge clk) disable iff (reset)
    (state_q == FLUSH && state_d == IDLE) |=> k_ready);

endmodule

// File: doc/keccak_arbiter.md
Name: keccak_arbiter

Overview:
- Shares one keccak hashing instance between two message requesters, granting one whole message at a time in round-robin order.
- Forwards the granted requester's words into the core and waits for the digest.
- Captures the digest into a result slot tagged with the owner ID.
- Resets the core between messages. The core's last-block flag is only cleared by reset, so every message must start from a freshly reset core.

Parameters:
- FLUSH_CYCLES, 2: number of cycles the core reset is held after each digest (minimum 1).
- TIMEOUT, 4096: maximum cycles spent in WAIT_DIGEST before the message is aborted.
- TW, $clog2(TIMEOUT+1): width of the watchdog counter (derived, not overridable).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has a word
- req0_data / req1_data  in  IN_BUF_SIZE  message word
- req0_last / req1_last  in  1  word belongs to the final block (forwarded to the core last_block)
- req0_eom / req1_eom  in  1  final word of the message
- req0_ready / req1_ready  out  1  word accepted this cycle when valid&ready
- k_din  out  IN_BUF_SIZE  to core din
- k_din_valid  out  1  to core din_valid
- k_last_block  out  1  to core last_block
- k_reset  out  1  core reset = reset | (state==FLUSH)
- k_buffer_full  in  1  from core
- k_ready  in  1  from core
- k_dout  in  256  core dout_all
- k_dout_valid  in  1  core final dout_valid
- res_valid  out  1  result slot occupied
- res_id  out  1  owner of the result
- res_digest  out  256  captured digest
- res_error  out  1  result is a timeout abort (digest = 0)
- res_ready  in  1  consumer pops the slot
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, last_grant=1 (so req0 wins first), res_valid=0, res_id=0, res_digest=0, res_error=0, all reqX_ready=0, k_din_valid=0, watchdog=0. Reset mid-message discards the message and any pending result.
- States: IDLE, FEED, WAIT_DIGEST, FLUSH.
- IDLE: arbitration happens only when the slot is free or being popped this cycle (res_valid=0 or res_ready=1).
  - If exactly one reqX_valid, grant X.
  - If both are valid, grant the one that is not last_grant.
  - On a grant: register grant, update last_grant, go to FEED next cycle. No word is accepted in IDLE.
- FEED:
  - reqG_ready = !k_buffer_full; the other requester's ready is 0.
  - k_din_valid = reqG_valid & reqG_ready. k_din and k_last_block are driven combinationally from the granted requester.
  - An accepted word with eom=1 moves to WAIT_DIGEST and clears the watchdog.
  - eom without last is a requester protocol error; it is not checked (assertion only).
- WAIT_DIGEST:
  - No words are accepted. The watchdog increments every cycle.
  - k_dout_valid=1: capture res_digest=k_dout, res_id=grant, res_error=0, res_valid=1, then go to FLUSH.
  - Watchdog reaches TIMEOUT-1 with no digest: res_error=1, res_digest=0, res_valid=1, then go to FLUSH.
  - If k_dout_valid and the timeout occur in the same cycle, the digest wins.
- FLUSH:
  - k_reset is held high for exactly FLUSH_CYCLES cycles (counter), then the state returns to IDLE.
  - The slot is free by construction at capture time, because a grant requires a free slot.
- Slot handshake: res_valid=1 and res_ready=1 clears res_valid on the next edge. res_digest, res_id and res_error hold until cleared. A pop and a new grant in the same IDLE cycle are legal.
- k_ready is monitored only (assertion: k_ready=1 in IDLE after FLUSH). Acceptance does not depend on it.
- Latency:
  - Request in IDLE to first accepted word: 1 cycle.
  - Digest to res_valid: 1 cycle.
  - Digest to next grant possible: 1+FLUSH_CYCLES cycles.

Decomposition:
- pkg_keccak: add typedef arb_state_t (IDLE, FEED, WAIT_DIGEST, FLUSH) and the constants KA_FLUSH_CYCLES and KA_TIMEOUT used as defaults. IN_BUF_SIZE comes from the same package.
- One sub-module, keccak_result_slot: the 1-entry valid/ready register for digest, id and error, with a capture input.
- The arbiter FSM and the counters stay in keccak_arbiter.

Test Plan:
- Single message from req0: 3 words, last on all, eom on word 3, core returns digest 0xA5..A5 → res_valid=1, res_id=0, res_digest=0xA5..A5, k_reset high for exactly 2 cycles after capture, req1_ready=0 throughout.
- Both requesters valid out of reset → req0 granted first, req1 granted after req0's flush. A third back-to-back pair with both valid → req0 next (alternation 0,1,0).
- k_buffer_full held high for 5 cycles mid-message → reqG_ready=0 and k_din_valid=0 for those 5 cycles; no word is lost or duplicated (compare the k_din sequence against the sent words).
- Result not popped (res_ready=0) while req1 waits → no grant until res_ready=1; pop and grant occur in the same cycle and FEED starts the next cycle.
- No k_dout_valid after eom with TIMEOUT=16 → res_error=1 and res_digest=0 on cycle 16 of WAIT_DIGEST, followed by FLUSH. Repeat with k_dout_valid on the timeout cycle → digest captured, res_error=0.
- reset asserted during FEED and during FLUSH → next cycle all outputs are at reset values and state is IDLE; the next message completes normally.
